// File: rtl/multiplier_pkg.sv
// Types shared by the Montgomery multiplier family of blocks.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_X = 2'd1,
    SHIFT_Z = 2'd2,
    DONE    = 2'd3
  } enc_state_t;

endpackage

// File: rtl/params_pkg.sv
// Shared arithmetic parameters for the Montgomery datapath blocks.
// Operand width plus the fixed modulus constants used by the reduction core.
package params_pkg;

  localparam int DATA_LENGTH = 64;

  localparam logic [DATA_LENGTH-1:0] MODULUS        = 64'h0000_0000_007F_E001;
  localparam int                     MODULUS_LENGTH = 23;

  // Newton iteration for MODULUS^-1 mod 2^DATA_LENGTH; each pass doubles the
  // number of correct low bits, starting from 3 for any odd modulus.
  function automatic logic [DATA_LENGTH-1:0] mod_inverse(input logic [DATA_LENGTH-1:0] m);
    logic [DATA_LENGTH-1:0] inv;
    inv = m;
    for (int i = 0; i < 5; i++) begin
      inv = inv * (DATA_LENGTH'(2) - m * inv);
    end
    return inv;
  endfunction

  localparam logic [DATA_LENGTH-1:0] MOD_INV = mod_inverse(MODULUS);

endpackage

// File: rtl/mod_double_step.sv
// One restoring-division step: next = (2r + in_bit) reduced once by m.
// Correct whenever r < m on entry, which keeps the result below m.
module mod_double_step #(
  parameter int DATA_LENGTH = params_pkg::DATA_LENGTH
) (
  input  logic [DATA_LENGTH:0]   r,
  input  logic                   in_bit,
  input  logic [DATA_LENGTH-1:0] m,
  output logic [DATA_LENGTH:0]   r_next
);

  localparam int RW = DATA_LENGTH + 1;
  localparam int TW = DATA_LENGTH + 2;

  logic [TW-1:0] t;
  logic [TW-1:0] m_ext;

  // One extra bit of headroom so 2r+b never wraps, even for r near 2^DATA_LENGTH.
  always_comb begin
    t      = {r, in_bit};
    m_ext  = {2'b00, m};
    r_next = (t >= m_ext) ? RW'(t - m_ext) : RW'(t);
  end

endmodule

// File: rtl/montgomery_domain_enc.sv
// Montgomery-domain encoder: result = x * 2^k mod m by bit-serial long division.
// Fixed latency of DATA_LENGTH + k + 1 cycles from the accepted start edge.
//
// state   | meaning
// IDLE    | waiting for start_i; result_o holds the last answer
// SHIFT_X | shifting operand bits into the remainder, MSB first
// SHIFT_Z | shifting k zero bits (the 2^k factor)
// DONE    | publish result with a one-cycle valid_o pulse
module montgomery_domain_enc
  import multiplier_pkg::*;
#(
  parameter int DATA_LENGTH = params_pkg::DATA_LENGTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int                     CW   = $clog2(DATA_LENGTH);
  localparam logic [DATA_LENGTH-1:0] DL_W = DATA_LENGTH'(DATA_LENGTH);
  localparam logic [CW-1:0]          CNT_TOP = CW'(DATA_LENGTH - 1);

  enc_state_t             state_q;
  logic [DATA_LENGTH-1:0] x_q;
  logic [DATA_LENGTH-1:0] m_q;
  logic [CW-1:0]          k_last_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_LENGTH:0]   r_q;
  logic                   err_q;

  logic                   illegal;
  logic                   step_bit;
  logic [DATA_LENGTH:0]   r_next;

  always_comb begin
    illegal  = (m_i == '0) || (m_bl_i == '0) || (m_bl_i > DL_W);
    step_bit = (state_q == SHIFT_X) ? x_q[cnt_q] : 1'b0;
  end

  mod_double_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .r      (r_q),
    .in_bit (step_bit),
    .m      (m_q),
    .r_next (r_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      x_q      <= '0;
      m_q      <= '0;
      k_last_q <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      err_q    <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            x_q      <= x_i;
            m_q      <= m_i;
            // k = DATA_LENGTH wraps to zero in CW bits, so k-1 lands on CNT_TOP.
            k_last_q <= m_bl_i[CW-1:0] - CW'(1);
            cnt_q    <= CNT_TOP;
            r_q      <= '0;
            busy_o   <= 1'b1;
            err_q    <= illegal;
            state_q  <= illegal ? DONE : SHIFT_X;
          end
        end
        SHIFT_X: begin
          r_q <= r_next;
          if (cnt_q == '0) begin
            cnt_q   <= k_last_q;
            state_q <= SHIFT_Z;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        SHIFT_Z: begin
          r_q <= r_next;
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          result_o <= err_q ? '0 : r_q[DATA_LENGTH-1:0];
          valid_o  <= 1'b1;
          err_o    <= err_q;
          busy_o   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_domain_enc.sv
// Self-checking bench for montgomery_domain_enc against an arithmetic model
// of x * 2^k mod m, with a per-cycle compare of the handshake outputs.
module tb_montgomery_domain_enc;

  localparam int          DL = 64;
  localparam logic [63:0] Q  = 64'h7FE001;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [63:0] x_i;
  logic [63:0] m_i;
  logic [63:0] m_bl_i;
  logic [63:0] result_o;
  logic        valid_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  montgomery_domain_enc dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .x_i      (x_i),
    .m_i      (m_i),
    .m_bl_i   (m_bl_i),
    .result_o (result_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_illegal(input logic [63:0] m, input logic [63:0] k);
    return (m == 64'd0) || (k == 64'd0) || (k > 64'd64);
  endfunction

  // Plain modular arithmetic on wide integers: (x mod m) doubled k times.
  function automatic logic [63:0] enc_model(input logic [63:0] x, input logic [63:0] m,
                                            input logic [63:0] k);
    logic [127:0] p;
    logic [127:0] mm;
    if (is_illegal(m, k)) return 64'd0;
    mm = {64'd0, m};
    p  = {64'd0, x} % mm;
    for (int i = 0; i < int'(k); i++) p = (p << 1) % mm;
    return p[63:0];
  endfunction

  // Undo the encoding: multiply by 2^-k mod an odd m via repeated halving.
  function automatic logic [63:0] from_mont(input logic [63:0] y, input logic [63:0] m,
                                            input int k);
    logic [64:0] t;
    t = {1'b0, y};
    for (int i = 0; i < k; i++) t = t[0] ? (t + {1'b0, m}) >> 1 : t >> 1;
    return t[63:0];
  endfunction

  // Reference model and per-cycle compare.
  int          cyc = 0;
  int          done_cyc = 0;
  bit          active = 0;
  bit          e_ill = 0;
  logic [63:0] e_res = '0;
  logic [63:0] hold = '0;
  int          vcount = 0;

  always @(posedge clk_i) begin
    logic e_valid, e_busy, e_err;
    cyc++;
    if (!rst_ni) begin
      active = 0;
      hold   = '0;
    end else begin
      if (active && cyc == done_cyc) hold = e_res;
      if (start_i && (!active || cyc > done_cyc)) begin
        e_ill    = is_illegal(m_i, m_bl_i);
        e_res    = enc_model(x_i, m_i, m_bl_i);
        done_cyc = e_ill ? cyc + 1 : cyc + DL + int'(m_bl_i[6:0]) + 1;
        active   = 1;
      end
    end
    e_valid = active && (cyc == done_cyc);
    e_busy  = active && (cyc < done_cyc);
    e_err   = e_valid && e_ill;
    #2;
    if (valid_o) vcount++;
    chk("valid_o", {63'd0, valid_o}, {63'd0, e_valid});
    chk("busy_o", {63'd0, busy_o}, {63'd0, e_busy});
    chk("err_o", {63'd0, err_o}, {63'd0, e_err});
    chk("result_o", result_o, hold);
  end

  task automatic run_op(input logic [63:0] x, input logic [63:0] m, input logic [63:0] k,
                        output logic [63:0] res, output int lat, output logic err);
    @(negedge clk_i);
    x_i = x; m_i = m; m_bl_i = k; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0; res = '0; err = 1'b0;
    while (lat < 300) begin
      x_i    = {$urandom, $urandom};
      m_i    = {$urandom, $urandom};
      m_bl_i = 64'($urandom_range(0, 80));
      @(posedge clk_i);
      #3;
      lat++;
      if (valid_o) begin
        res = result_o;
        err = err_o;
        break;
      end
    end
    if (lat >= 300) chk("valid_timeout", {63'd0, valid_o}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [63:0] res, x, m, k;
    logic        err;
    int          lat;

    rst_ni = 1'b0; start_i = 1'b0; x_i = '0; m_i = '0; m_bl_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_result", result_o, 64'd0);
    chk("reset_valid", {63'd0, valid_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_err", {63'd0, err_o}, 64'd0);
    rst_ni = 1'b1;

    run_op(64'd1, Q, 64'd23, res, lat, err);
    chk("x1_result", res, 64'h1FFF);
    chk("x1_latency", 64'(lat), 64'd88);
    chk("x1_err", {63'd0, err}, 64'd0);
    run_op(64'd0, Q, 64'd23, res, lat, err);
    chk("x0_result", res, 64'd0);
    run_op(Q, Q, 64'd23, res, lat, err);
    chk("xq_result", res, 64'd0);
    run_op(64'd2, Q, 64'd23, res, lat, err);
    chk("x2_result", res, 64'h3FFE);
    run_op(Q - 64'd1, Q, 64'd23, res, lat, err);
    chk("xqm1_result", res, 64'h7FC002);
    chk("xqm1_err", {63'd0, err}, 64'd0);
    run_op(64'h123456, Q, 64'd23, res, lat, err);
    chk("roundtrip_fixed", from_mont(res, Q, 23), 64'h123456);

    // Boundary k and modulus values.
    run_op(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, res, lat, err);
    chk("k64_result", res, 64'd5);
    chk("k64_latency", 64'(lat), 64'd129);
    run_op(64'd7, 64'd3, 64'd1, res, lat, err);
    chk("k1_result", res, 64'd2);
    chk("k1_latency", 64'(lat), 64'd66);
    run_op(64'd7, 64'd10, 64'd4, res, lat, err);
    chk("even_m_result", res, 64'd2);

    // Illegal operands answer on the next edge with err_o.
    run_op(64'd9, 64'd0, 64'd23, res, lat, err);
    chk("m0_latency", 64'(lat), 64'd1);
    chk("m0_err", {63'd0, err}, 64'd1);
    chk("m0_result", res, 64'd0);
    run_op(64'd9, Q, 64'd65, res, lat, err);
    chk("bl65_latency", 64'(lat), 64'd1);
    chk("bl65_err", {63'd0, err}, 64'd1);
    chk("bl65_result", res, 64'd0);
    run_op(64'd9, Q, 64'd0, res, lat, err);
    chk("bl0_err", {63'd0, err}, 64'd1);

    for (int i = 0; i < 300; i++) begin
      x = {$urandom, $urandom};
      run_op(x, Q, 64'd23, res, lat, err);
      chk("rand_q_result", res, enc_model(x, Q, 64'd23));
      chk("rand_q_roundtrip", from_mont(res, Q, 23), x % Q);
    end

    for (int i = 0; i < 80; i++) begin
      x = {$urandom, $urandom};
      m = {$urandom, $urandom};
      if (m == 64'd0) m = 64'd1;
      k = 64'($urandom_range(1, 64));
      run_op(x, m, k, res, lat, err);
      chk("rand_m_result", res, enc_model(x, m, k));
      chk("rand_m_latency", 64'(lat), 64'd65 + k);
    end

    // Starts while busy (edges 10 and 88) are ignored; edge 89 is accepted.
    @(negedge clk_i);
    vcount = 0;
    x_i = 64'd2; m_i = Q; m_bl_i = 64'd23; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    x_i = 64'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (77) @(negedge clk_i);
    x_i = 64'd1; start_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (100) @(negedge clk_i);
    chk("busy_restart_pulses", 64'(vcount), 64'd2);
    chk("busy_restart_result", result_o, 64'h1FFF);

    // Reset in the middle of a run.
    x_i = 64'd2; m_i = Q; m_bl_i = 64'd23; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (39) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy_o}, 64'd0);
    chk("midreset_valid", {63'd0, valid_o}, 64'd0);
    chk("midreset_result", result_o, 64'd0);
    chk("midreset_err", {63'd0, err_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op(64'd1, Q, 64'd23, res, lat, err);
    chk("post_reset_result", res, 64'h1FFF);
    chk("post_reset_latency", 64'(lat), 64'd88);

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
